// File: rtl/div_iter_pkg.sv
// Shared names for the iterative divider and its EX-stage handshake:
// state encodings, start/ready levels, zero word and a debug view of the FSM.
package div_iter_pkg;

    localparam logic [1:0] DivFree   = 2'd0;
    localparam logic [1:0] DivByZero = 2'd1;
    localparam logic [1:0] DivOn     = 2'd2;
    localparam logic [1:0] DivEnd    = 2'd3;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef struct packed {
        logic [1:0] state;
        logic [4:0] count;
        logic       neg_q;
        logic       neg_r;
    } div_dbg_t;

    // Magnitude of a signed operand; 0x80000000 maps to itself read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 step: shift the 65-bit remainder/quotient word left
// and keep the trial subtraction of the divisor when it does not go negative.
module div_step
    import div_iter_pkg::*;
(
    input  logic [64:0] rq,
    input  logic [31:0] divisor,
    output logic [64:0] rq_next
);

    logic [64:0] shifted;
    logic [32:0] diff;

    assign shifted = rq << 1;
    // The partial remainder stays below twice the divisor, so bit 32 of the
    // 33-bit difference is exactly the borrow.
    assign diff    = shifted[64:32] - {1'b0, divisor};
    assign rq_next = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider returning {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to short-cut zero divisors through the BYZERO state.
module div_iter
    import div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output div_dbg_t    dbg_o
);

    // Handshake: EX raises start_i with stable operands and holds it until it
    // sees ready_o; ready_o is high only in END and result_o is valid only then.

    logic [1:0]  state;
    logic [4:0]  count;
    logic [64:0] rq;
    logic [64:0] rq_next;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [63:0] result_fix;

    div_step u_step (
        .rq      (rq),
        .divisor (divisor),
        .rq_next (rq_next)
    );

    always_comb begin
        q_fix      = neg_q ? (~rq_next[31:0] + 32'd1)  : rq_next[31:0];
        r_fix      = neg_r ? (~rq_next[63:32] + 32'd1) : rq_next[63:32];
        result_fix = (divisor == ZeroWord) ? {ZeroWord, ZeroWord} : {r_fix, q_fix};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DivFree;
            count    <= 5'd0;
            rq       <= 65'd0;
            divisor  <= ZeroWord;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        divisor <= abs32(opdata2_i, signed_div_i);
                        rq      <= {33'd0, abs32(opdata1_i, signed_div_i)};
                        neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r   <= signed_div_i & opdata1_i[31];
                        count   <= 5'd0;
`ifdef DIV_ZERO_FAST_EN
                        state   <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
`else
                        state   <= DivOn;
`endif
                    end
                end
                DivByZero: begin
                    result_o <= {ZeroWord, ZeroWord};
                    state    <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        rq    <= rq_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            result_o <= result_fix;
                            state    <= DivEnd;
                        end
                    end
                end
                default: begin
                    if (start_i == DivStop) begin
                        state <= DivFree;
                    end
                end
            endcase
        end
    end

    assign ready_o = (state == DivEnd) ? DivResultReady : DivResultNotReady;
    assign dbg_o   = '{state: state, count: count, neg_q: neg_q, neg_r: neg_r};

endmodule
